// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if
// Bundles the serial input side and the parallel output side of the
// deserializer.
//   Sin, Sin_en : serial data line (idle 1) and its sample strobe
//   Ack         : consumer acknowledge for the held word
//   Pout        : received 8-bit word
//   Valid       : Pout holds an unacknowledged word
//   Parity_err  : parity result for the word on Pout
//   Frame_err   : one-cycle pulse on a bad stop bit
//   Busy        : high whenever the receiver is not idle
// master = producer/consumer side (testbench), slave = the deserializer.
interface sipo_deserializer_if;
  logic       Sin;
  logic       Sin_en;
  logic       Ack;
  logic [7:0] Pout;
  logic       Valid;
  logic       Parity_err;
  logic       Frame_err;
  logic       Busy;

  modport master (
    output Sin, Sin_en, Ack,
    input  Pout, Valid, Parity_err, Frame_err, Busy
  );

  modport slave (
    input  Sin, Sin_en, Ack,
    output Pout, Valid, Parity_err, Frame_err, Busy
  );
endinterface

// File: rtl/sipo_deserializer.sv
// sipo_deserializer
// Serial-in / parallel-out receiver for frames of the form
//   start(0), d0..d7 (LSB first), even parity, stop(1).
// Sin is only examined on edges where Sin_en=1. A good frame is held on
// Pout with Valid=1 until Ack is sampled; frames arriving meanwhile are
// dropped silently. A bad stop bit pulses Frame_err and discards the word.
// Ports:
//   Clk   : rising-edge clock
//   Rst_n : asynchronous active-low reset
//   bus   : sipo_deserializer_if.slave (Sin/Sin_en/Ack in, Pout/Valid/
//           Parity_err/Frame_err/Busy out)
module sipo_deserializer (
  input  logic                  Clk,
  input  logic                  Rst_n,
  sipo_deserializer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_PARITY, S_STOP, S_HOLD
  } state_t;

  state_t     r_state,      w_state_nxt;
  logic [2:0] r_cnt,        w_cnt_nxt;
  logic [7:0] r_shreg,      w_shreg_nxt;
  logic       r_perr,       w_perr_nxt;
  logic [7:0] r_pout,       w_pout_nxt;
  logic       r_valid,      w_valid_nxt;
  logic       r_parity_err, w_parity_err_nxt;
  logic       r_frame_err,  w_frame_err_nxt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_shreg      <= 8'h00;
      r_perr       <= 1'b0;
      r_pout       <= 8'h00;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_perr       <= w_perr_nxt;
      r_pout       <= w_pout_nxt;
      r_valid      <= w_valid_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_shreg_nxt      = r_shreg;
    w_perr_nxt       = r_perr;
    w_pout_nxt       = r_pout;
    w_valid_nxt      = r_valid;
    w_parity_err_nxt = r_parity_err;
    w_frame_err_nxt  = 1'b0;          // pulse: only set for one edge

    case (r_state)
      S_IDLE: begin
        if (bus.Sin_en && !bus.Sin) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (bus.Sin_en) begin
          // Right shift: after 8 samples the first (LSB) bit sits in [0].
          w_shreg_nxt = {bus.Sin, r_shreg[7:1]};
          w_cnt_nxt   = r_cnt + 3'd1;   // 7 -> 0 wraps as we leave DATA
          if (r_cnt == 3'd7)
            w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (bus.Sin_en) begin
          w_perr_nxt  = (^r_shreg) ^ bus.Sin;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (bus.Sin_en) begin
          if (bus.Sin) begin
            w_pout_nxt       = r_shreg;
            w_parity_err_nxt = r_perr;
            w_valid_nxt      = 1'b1;
            w_state_nxt      = S_HOLD;
          end else begin
            w_frame_err_nxt  = 1'b1;
            w_state_nxt      = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // Serial input is deliberately ignored while a word is held.
        if (bus.Ack) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.Pout       = r_pout;
  assign bus.Valid      = r_valid;
  assign bus.Parity_err = r_parity_err;
  assign bus.Frame_err  = r_frame_err;
  assign bus.Busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

  logic Clk;
  logic Rst_n;
  sipo_deserializer_if bus ();

  sipo_deserializer dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the consumer should currently see.
  logic [7:0] exp_pout;
  logic       exp_valid;
  logic       exp_perr;
  logic       exp_ferr;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    exp_pout  = 8'h00;
    exp_valid = 1'b0;
    exp_perr  = 1'b0;
    exp_ferr  = 1'b0;
  endtask

  // Sends one frame; before every bit, 'gap' cycles with Sin_en=0 and Sin
  // toggling. With noise set, Ack is randomly asserted inside those gaps
  // (never while a word is held, since those gaps follow the start bit).
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp,
                            input int gap, input bit noise, input string nm);
    logic [10:0] bits;
    bits = {stp, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.Sin_en = 1'b0;
        bus.Sin    = ~bus.Sin;
        bus.Ack    = (noise && i > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      bus.Ack    = 1'b0;
      bus.Sin_en = 1'b1;
      bus.Sin    = bits[i];
      tick();
      if (i == 0) begin
        n_checks++;
        if (bus.Busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy_after_start: got %b want 1", nm, bus.Busy);
        end
      end
    end
    bus.Sin_en = 1'b0;
    bus.Sin    = 1'b1;
    // Model: frame only lands if nothing was held.
    if (!exp_valid) begin
      if (stp) begin
        exp_pout  = d;
        exp_perr  = (^d) ^ p;
        exp_valid = 1'b1;
        exp_ferr  = 1'b0;
      end else begin
        exp_ferr  = 1'b1;
      end
    end else begin
      exp_ferr = 1'b0;
    end
    n_checks++;
    if (bus.Valid !== exp_valid || bus.Pout !== exp_pout ||
        bus.Parity_err !== exp_perr || bus.Frame_err !== exp_ferr ||
        bus.Busy !== exp_valid) begin
      n_fail++;
      $display("FAIL %s stop_edge: got v=%b pout=%h perr=%b ferr=%b busy=%b want v=%b pout=%h perr=%b ferr=%b busy=%b",
               nm, bus.Valid, bus.Pout, bus.Parity_err, bus.Frame_err, bus.Busy,
               exp_valid, exp_pout, exp_perr, exp_ferr, exp_valid);
    end
    tick();
    exp_ferr = 1'b0;
    n_checks++;
    if (bus.Frame_err !== 1'b0 || bus.Valid !== exp_valid || bus.Pout !== exp_pout) begin
      n_fail++;
      $display("FAIL %s after_stop: got ferr=%b v=%b pout=%h want ferr=0 v=%b pout=%h",
               nm, bus.Frame_err, bus.Valid, bus.Pout, exp_valid, exp_pout);
    end
  endtask

  task automatic do_ack(input string nm);
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
    exp_valid = 1'b0;
    n_checks++;
    if (bus.Valid !== 1'b0 || bus.Busy !== 1'b0 || bus.Pout !== exp_pout) begin
      n_fail++;
      $display("FAIL %s ack: got v=%b busy=%b pout=%h want v=0 busy=0 pout=%h",
               nm, bus.Valid, bus.Busy, bus.Pout, exp_pout);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    bus.Sin = 1'b1; bus.Sin_en = 1'b0; bus.Ack = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.Pout !== 8'h00 || bus.Valid !== 1'b0 || bus.Parity_err !== 1'b0 ||
        bus.Frame_err !== 1'b0 || bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got pout=%h v=%b perr=%b ferr=%b busy=%b want all 0",
               bus.Pout, bus.Valid, bus.Parity_err, bus.Frame_err, bus.Busy);
    end
    tick(); tick();
    Rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b v=%b want 0 0", bus.Busy, bus.Valid);
    end
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0, "good");
    n_checks++;
    if (bus.Pout !== 8'hA5 || bus.Parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL good_const: got pout=%h perr=%b want a5 0", bus.Pout, bus.Parity_err);
    end
    do_ack("good");
  endtask

  task automatic test_parity_err();
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0, "parity");
    n_checks++;
    if (bus.Parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_const: got perr=%b want 1", bus.Parity_err);
    end
    do_ack("parity");
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, "frame");
  endtask

  task automatic test_strobe_gating();
    send_frame(8'h81, 1'b0, 1'b1, 3, 1'b0, "strobe");
    do_ack("strobe");
  endtask

  task automatic test_reset_midframe();
    logic [4:0] part;
    part = 5'b11110;                      // start bit then 4 data bits of 0x0F
    for (int i = 0; i < 5; i++) begin
      bus.Sin_en = 1'b1;
      bus.Sin    = part[i];
      tick();
    end
    #2 Rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.Pout !== 8'h00 || bus.Valid !== 1'b0 || bus.Parity_err !== 1'b0 ||
        bus.Frame_err !== 1'b0 || bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midframe: got pout=%h v=%b perr=%b ferr=%b busy=%b want all 0",
               bus.Pout, bus.Valid, bus.Parity_err, bus.Frame_err, bus.Busy);
    end
    bus.Sin_en = 1'b0; bus.Sin = 1'b1;
    tick();
    Rst_n = 1'b1;
    tick();
    send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0, "post_reset");
    do_ack("post_reset");
  endtask

  task automatic test_hold();
    logic [10:0] bits;
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0, "hold_first");
    bits = {1'b1, 1'b0, 8'hFF, 1'b0};
    for (int c = 0; c < 20; c++) begin
      bus.Sin_en = 1'b1;
      bus.Sin    = (c < 11) ? bits[c] : 1'b1;
      tick();
      n_checks++;
      if (bus.Valid !== 1'b1 || bus.Pout !== 8'hA5 || bus.Frame_err !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got v=%b pout=%h ferr=%b want v=1 pout=a5 ferr=0",
                 c, bus.Valid, bus.Pout, bus.Frame_err);
      end
    end
    bus.Sin_en = 1'b0; bus.Sin = 1'b1;
    do_ack("hold");
    for (int c = 0; c < 15; c++) begin
      bus.Sin_en = 1'b1;
      tick();
      n_checks++;
      if (bus.Valid !== 1'b0 || bus.Busy !== 1'b0 || bus.Pout !== 8'hA5) begin
        n_fail++;
        $display("FAIL hold_after%0d: got v=%b busy=%b pout=%h want v=0 busy=0 pout=a5",
                 c, bus.Valid, bus.Busy, bus.Pout);
      end
    end
    bus.Sin_en = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       p, stp;
    for (int n = 0; n < 30; n++) begin
      d   = 8'($urandom_range(0, 255));
      p   = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      stp = ($urandom_range(0, 4) != 0);
      send_frame(d, p, stp, int'($urandom_range(0, 2)), 1'b1, "random");
      if (exp_valid) begin
        repeat ($urandom_range(0, 3)) begin
          bus.Sin_en = 1'($urandom_range(0, 1));
          bus.Sin    = 1'($urandom_range(0, 1));
          tick();
        end
        bus.Sin_en = 1'b0; bus.Sin = 1'b1;
        do_ack("random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_strobe_gating();
    test_reset_midframe();
    test_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
